viterbi_traceback: RTL and testbench

Traceback unit for the Viterbi decoder: the read-side counterpart of the MMU survivor store. On a start request it walks the survivor RAM backwards from a given page and state, one page per step, reconstructing the surviving path. It discards the first `TB_SKIP` convergence steps and emits the remaining decoded bits in chronological order over a valid/ready stream. It sits between the MMU read port (`TBPage`/`AddressTB` out, `DataTB` in) and the decoder output.

---
 rtl/viterbi_traceback.sv | 148 ++++++++++++++
 tb/tb_viterbi_traceback.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Viterbi traceback unit: walks the survivor RAM backwards one page per step,
// drops the convergence steps and streams the remaining decoded bits oldest-first.
module viterbi_traceback #(
    parameter int WD_STATE      = 8,
    parameter int WD_DEPTH      = 6,
    parameter int WD_RAM_DATA   = 8,
    parameter int WD_TB_ADDRESS = 5,
    parameter int TB_LEN        = 48,
    parameter int TB_SKIP       = 32,
    parameter int RD_LAT        = 2
) (
    input  logic                     CLOCK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [WD_DEPTH-1:0]      StartPage,
    input  logic [WD_STATE-1:0]      StartState,
    output logic                     Busy,
    output logic                     Read_Req,
    output logic [WD_DEPTH-1:0]      TBPage,
    output logic [WD_TB_ADDRESS-1:0] AddressTB,
    input  logic [WD_RAM_DATA-1:0]   DataTB,
    output logic                     Out_Valid,
    output logic                     Out_Bit,
    input  logic                     Out_Ready,
    output logic                     Done
);

    localparam int WD_SEL = WD_STATE - WD_TB_ADDRESS;
    localparam int N_OUT  = TB_LEN - TB_SKIP;
    localparam int WD_K   = $clog2(TB_LEN + 1);
    localparam int WD_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WD_LAT = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [WD_DEPTH-1:0]   page_q, page_d;
    logic [WD_STATE-1:0]   tstate_q, tstate_d;
    logic [WD_K-1:0]       k_q, k_d;
    logic [WD_LAT-1:0]     lat_q, lat_d;
    logic [WD_IDX-1:0]     idx_q, idx_d;
    logic [N_OUT-1:0]      bits_q, bits_d;
    logic [N_OUT-1:0]      slot_we;

    logic                  last_wait;
    logic                  surv;
    logic                  handshake;
    logic                  run_done;
    logic                  addr_en;

    assign last_wait = (fsm_q == S_WAIT) && (lat_q == WD_LAT'(RD_LAT - 1));
    assign surv      = DataTB[tstate_q[WD_SEL-1:0]];
    assign handshake = (fsm_q == S_EMIT) && Out_Ready;
    assign run_done  = handshake && (idx_q == '0);
    assign addr_en   = (fsm_q == S_ISSUE) || (fsm_q == S_WAIT);

    // Step k lands in slot k-TB_SKIP, so the highest slot holds the oldest bit.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_slot
            assign slot_we[gi] = last_wait && (k_q == WD_K'(TB_SKIP + gi));
            assign bits_d[gi]  = slot_we[gi] ? tstate_q[WD_STATE-1] : bits_q[gi];
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            fsm_q    <= S_IDLE;
            page_q   <= '0;
            tstate_q <= '0;
            k_q      <= '0;
            lat_q    <= '0;
            idx_q    <= '0;
            bits_q   <= '0;
        end else begin
            fsm_q    <= fsm_d;
            page_q   <= page_d;
            tstate_q <= tstate_d;
            k_q      <= k_d;
            lat_q    <= lat_d;
            idx_q    <= idx_d;
            bits_q   <= bits_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        page_d   = page_q;
        tstate_d = tstate_q;
        k_d      = k_q;
        lat_d    = lat_q;
        idx_d    = idx_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (Start) begin
                    page_d   = StartPage;
                    tstate_d = StartState;
                    k_d      = '0;
                    fsm_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d = '0;
                fsm_d = S_WAIT;
            end
            S_WAIT: begin
                if (last_wait) begin
                    // Page wraps naturally through the modular subtraction.
                    tstate_d = {tstate_q[WD_STATE-2:0], surv};
                    page_d   = page_q - 1'b1;
                    k_d      = k_q + 1'b1;
                    if (k_q == WD_K'(TB_LEN - 1)) begin
                        idx_d = WD_IDX'(N_OUT - 1);
                        fsm_d = S_EMIT;
                    end else begin
                        fsm_d = S_ISSUE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    if (idx_q == '0) begin
                        fsm_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign Busy      = (fsm_q != S_IDLE) && !run_done;
    assign Read_Req  = (fsm_q == S_ISSUE);
    assign TBPage    = addr_en ? page_q : '0;
    assign AddressTB = addr_en ? tstate_q[WD_STATE-1:WD_SEL] : '0;
    assign Out_Valid = (fsm_q == S_EMIT);
    assign Out_Bit   = (fsm_q == S_EMIT) ? bits_q[idx_q] : 1'b0;
    assign Done      = run_done;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: survivor RAM model with a two-stage
// read pipeline, one task per scenario, inline comparisons.
module tb_viterbi_traceback;

    logic       CLOCK = 1'b0;
    logic       Reset;
    logic       Start;
    logic [5:0] StartPage;
    logic [7:0] StartState;
    logic       Busy;
    logic       Read_Req;
    logic [5:0] TBPage;
    logic [4:0] AddressTB;
    logic [7:0] DataTB;
    logic       Out_Valid;
    logic       Out_Bit;
    logic       Out_Ready;
    logic       Done;

    always #5 CLOCK = ~CLOCK;

    viterbi_traceback dut (
        .CLOCK     (CLOCK),
        .Reset     (Reset),
        .Start     (Start),
        .StartPage (StartPage),
        .StartState(StartState),
        .Busy      (Busy),
        .Read_Req  (Read_Req),
        .TBPage    (TBPage),
        .AddressTB (AddressTB),
        .DataTB    (DataTB),
        .Out_Valid (Out_Valid),
        .Out_Bit   (Out_Bit),
        .Out_Ready (Out_Ready),
        .Done      (Done)
    );

    // Survivor memory with RD_LAT=2 registered read; garbage mode scrambles
    // DataTB on every cycle except the capture cycle.
    logic [7:0] mem [0:63][0:31];
    logic [7:0] d1, d2, garb;
    logic       rr1, rr2;
    logic       garbage_mode = 1'b0;

    always @(posedge CLOCK) begin
        d1   <= mem[TBPage][AddressTB];
        d2   <= d1;
        rr1  <= Read_Req;
        rr2  <= rr1;
        garb <= 8'($urandom);
    end
    assign DataTB = (garbage_mode && !rr2) ? garb : d2;

    int n_tests = 0;
    int n_fail  = 0;

    int   cap_page[$];
    int   cap_addr[$];
    int   cap_rr[$];
    bit   out_bits[$];
    int   done_cyc;
    bit   timed_out;
    bit   stall_bad;
    bit   rr_in_emit;
    logic busy_on_done;
    int   start_pulse_cyc = -1;
    int   stall_after = -1;
    int   stall_len = 0;

    task automatic fill_const(input logic [7:0] v);
        for (int p = 0; p < 64; p++)
            for (int a = 0; a < 32; a++)
                mem[p][a] = v;
    endtask

    // Forward-encode 0xA5C3 plus 32 zero tail bits from state 0x3C; input i
    // writes its survivor at page 3+i, so the final state sits at page 50.
    task automatic fill_path(output logic [7:0] final_s);
        logic [15:0] msg;
        logic [7:0]  s, sn;
        logic        u;
        int          pg;
        msg = 16'hA5C3;
        for (int p = 0; p < 64; p++)
            for (int a = 0; a < 32; a++)
                mem[p][a] = 8'($urandom);
        s = 8'h3C;
        for (int i = 0; i < 48; i++) begin
            u  = (i < 16) ? msg[15-i] : 1'b0;
            sn = {u, s[7:1]};
            pg = (3 + i) % 64;
            mem[pg][sn[7:3]][sn[2:0]] = s[0];
            s = sn;
        end
        final_s = s;
    endtask

    function automatic logic [15:0] packed_out();
        logic [15:0] v;
        v = '0;
        foreach (out_bits[i]) v = {v[14:0], out_bits[i]};
        return v;
    endfunction

    // Cycle 0 is the cycle in which Start is high.
    task automatic run_tb(input logic [5:0] sp, input logic [7:0] ss);
        int   cyc;
        int   stall_left;
        bit   held_valid;
        logic held_bit;
        bit   done_seen;
        bit   saw_valid;
        cap_page.delete();
        cap_addr.delete();
        cap_rr.delete();
        out_bits.delete();
        done_cyc     = -1;
        timed_out    = 0;
        stall_bad    = 0;
        rr_in_emit   = 0;
        busy_on_done = 1'bx;
        stall_left   = 0;
        held_valid   = 0;
        held_bit     = 1'b0;
        done_seen    = 0;
        saw_valid    = 0;
        @(posedge CLOCK); #1;
        Start      = 1'b1;
        StartPage  = sp;
        StartState = ss;
        Out_Ready  = 1'b1;
        cyc        = 0;
        while (!done_seen && cyc < 1000) begin
            if (cyc > 0) begin
                Start     = (cyc == start_pulse_cyc);
                Out_Ready = (stall_left == 0);
            end
            @(negedge CLOCK);
            if (Read_Req) begin
                cap_page.push_back(int'(TBPage));
                cap_addr.push_back(int'(AddressTB));
                cap_rr.push_back(cyc);
                if (saw_valid) rr_in_emit = 1;
            end
            if (!Out_Ready && stall_left > 0) stall_left--;
            if (Out_Valid) begin
                saw_valid = 1;
                if (held_valid && Out_Bit !== held_bit) stall_bad = 1;
                if (Out_Ready) begin
                    out_bits.push_back(Out_Bit);
                    held_valid = 0;
                    if (out_bits.size() == stall_after) stall_left = stall_len;
                end else begin
                    held_valid = 1;
                    held_bit   = Out_Bit;
                end
            end
            if (Done) begin
                done_seen    = 1;
                done_cyc     = cyc;
                busy_on_done = Busy;
            end
            @(posedge CLOCK); #1;
            cyc++;
        end
        Start     = 1'b0;
        Out_Ready = 1'b1;
        if (!done_seen) timed_out = 1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        n_tests++;
        if ({Busy, Read_Req, TBPage, AddressTB, Out_Valid, Out_Bit, Done} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {Busy, Read_Req, TBPage, AddressTB, Out_Valid, Out_Bit, Done});
        end
        @(posedge CLOCK); #1;
        Reset = 1'b0;
    endtask

    task automatic test_all_zero();
        int          bad;
        logic [5:0]  ep;
        logic [15:0] ov;
        fill_const(8'h00);
        run_tb(6'd10, 8'h00);
        n_tests++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL zero_timeout: got no Done expected Done within 1000 cycles");
        end
        n_tests++;
        if (cap_page.size() != 48) begin
            n_fail++;
            $display("FAIL zero_read_count: got %0d expected 48", cap_page.size());
        end
        bad = 0;
        for (int k = 0; k < cap_page.size(); k++) begin
            ep = 6'(10 - k);
            if (cap_page[k] != int'(ep)) bad++;
        end
        n_tests++;
        if (bad != 0 || cap_page.size() == 0 || cap_page[cap_page.size()-1] != 27) begin
            n_fail++;
            $display("FAIL zero_pages: got %0d wrong pages expected 0 (sequence 10 down to 27)", bad);
        end
        ov = packed_out();
        n_tests++;
        if (out_bits.size() != 16 || ov !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_output: got %0d bits %h expected 16 bits 0000", out_bits.size(), ov);
        end
        n_tests++;
        if (done_cyc != 160) begin
            n_fail++;
            $display("FAIL zero_done_time: got cycle %0d expected 160 (161 cycles incl. Start)", done_cyc);
        end
        n_tests++;
        if (busy_on_done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_on_done: got %b expected 0", busy_on_done);
        end
    endtask

    task automatic test_all_ones();
        int          bad;
        logic [15:0] ov;
        fill_const(8'hFF);
        run_tb(6'd5, 8'hFF);
        bad = 0;
        foreach (cap_addr[i]) if (cap_addr[i] != 31) bad++;
        n_tests++;
        if (bad != 0 || cap_addr.size() != 48) begin
            n_fail++;
            $display("FAIL ones_address: got %0d reads, %0d not 31 expected 48 reads all 31",
                     cap_addr.size(), bad);
        end
        n_tests++;
        if (cap_page.size() != 48 || cap_page[5] != 0 || cap_page[6] != 63 || cap_page[47] != 22) begin
            n_fail++;
            $display("FAIL ones_page_wrap: got %0d reads expected pages 0,63 at reads 5,6 and 22 last",
                     cap_page.size());
        end
        ov = packed_out();
        n_tests++;
        if (out_bits.size() != 16 || ov !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL ones_output: got %0d bits %h expected 16 bits ffff", out_bits.size(), ov);
        end
    endtask

    task automatic test_known_path();
        logic [7:0]  fs;
        logic [15:0] ov;
        fill_path(fs);
        run_tb(6'd50, fs);
        ov = packed_out();
        n_tests++;
        if (out_bits.size() != 16 || ov !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL path_output: got %0d bits %h expected 16 bits a5c3", out_bits.size(), ov);
        end
        n_tests++;
        if (cap_addr.size() == 0 || cap_addr[0] != int'(fs[7:3])) begin
            n_fail++;
            $display("FAIL path_first_address: got %0d reads expected first segment %0d",
                     cap_addr.size(), fs[7:3]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  fs;
        logic [15:0] ov;
        fill_path(fs);
        stall_after     = 3;
        stall_len       = 5;
        start_pulse_cyc = 150;
        run_tb(6'd50, fs);
        stall_after     = -1;
        stall_len       = 0;
        start_pulse_cyc = -1;
        ov = packed_out();
        n_tests++;
        if (out_bits.size() != 16 || ov !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL bp_output: got %0d bits %h expected 16 bits a5c3", out_bits.size(), ov);
        end
        n_tests++;
        if (stall_bad) begin
            n_fail++;
            $display("FAIL bp_bit_stable: got Out_Bit changing under stall expected stable");
        end
        n_tests++;
        if (rr_in_emit) begin
            n_fail++;
            $display("FAIL bp_start_ignored: got Read_Req during emission expected none");
        end
        n_tests++;
        if (done_cyc != 165) begin
            n_fail++;
            $display("FAIL bp_done_time: got cycle %0d expected 165", done_cyc);
        end
    endtask

    task automatic test_start_on_done();
        int extra_rr;
        int extra_busy;
        fill_const(8'h00);
        start_pulse_cyc = 160;
        run_tb(6'd10, 8'h00);
        start_pulse_cyc = -1;
        extra_rr   = 0;
        extra_busy = 0;
        repeat (8) begin
            @(negedge CLOCK);
            if (Read_Req) extra_rr++;
            if (Busy) extra_busy++;
        end
        n_tests++;
        if (done_cyc != 160 || extra_rr != 0 || extra_busy != 0) begin
            n_fail++;
            $display("FAIL start_on_done: got done %0d, %0d reads, %0d busy cycles expected 160,0,0",
                     done_cyc, extra_rr, extra_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int          nrr;
        int          cyc;
        int          bad;
        logic [5:0]  ep;
        logic [15:0] ov;
        fill_const(8'h00);
        @(posedge CLOCK); #1;
        Start      = 1'b1;
        StartPage  = 6'd10;
        StartState = 8'h00;
        Out_Ready  = 1'b1;
        nrr = 0;
        cyc = 0;
        while (nrr < 21 && cyc < 300) begin
            @(negedge CLOCK);
            if (Read_Req) nrr++;
            @(posedge CLOCK); #1;
            Start = 1'b0;
            cyc++;
        end
        n_tests++;
        if (nrr < 21) begin
            n_fail++;
            $display("FAIL midrun_reach_step20: got %0d reads expected 21", nrr);
        end
        Reset = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        n_tests++;
        if ({Busy, Read_Req, TBPage, AddressTB, Out_Valid, Out_Bit, Done} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got %h expected 0000",
                     {Busy, Read_Req, TBPage, AddressTB, Out_Valid, Out_Bit, Done});
        end
        Reset = 1'b0;
        run_tb(6'd10, 8'h00);
        bad = 0;
        for (int k = 0; k < cap_page.size(); k++) begin
            ep = 6'(10 - k);
            if (cap_page[k] != int'(ep)) bad++;
        end
        ov = packed_out();
        n_tests++;
        if (cap_page.size() != 48 || bad != 0 || ov !== 16'h0000 || out_bits.size() != 16
            || done_cyc != 160) begin
            n_fail++;
            $display("FAIL midrun_rerun: got %0d reads (%0d bad), out %h, done %0d expected 48,0,0000,160",
                     cap_page.size(), bad, ov, done_cyc);
        end
    endtask

    task automatic test_step_timing();
        logic [7:0]  fs;
        logic [15:0] ov;
        int          bad;
        fill_path(fs);
        garbage_mode = 1'b1;
        run_tb(6'd50, fs);
        garbage_mode = 1'b0;
        bad = 0;
        for (int i = 1; i < cap_rr.size(); i++)
            if (cap_rr[i] - cap_rr[i-1] != 3) bad++;
        n_tests++;
        if (cap_rr.size() != 48 || cap_rr[0] != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL timing_read_req: got %0d pulses, first at %0d, %0d bad gaps expected 48, 1, 0",
                     cap_rr.size(), (cap_rr.size() > 0) ? cap_rr[0] : -1, bad);
        end
        ov = packed_out();
        n_tests++;
        if (out_bits.size() != 16 || ov !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL timing_garbage_output: got %0d bits %h expected 16 bits a5c3",
                     out_bits.size(), ov);
        end
        n_tests++;
        if (done_cyc != 160) begin
            n_fail++;
            $display("FAIL timing_done: got cycle %0d expected 160", done_cyc);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        Start      = 1'b0;
        StartPage  = '0;
        StartState = '0;
        Out_Ready  = 1'b1;
        fill_const(8'h00);
        test_reset();
        test_all_zero();
        $display("[TB] all-zero run done, %0d failed so far", n_fail);
        test_all_ones();
        $display("[TB] all-ones run done, %0d failed so far", n_fail);
        test_known_path();
        $display("[TB] known-path run done, %0d failed so far", n_fail);
        test_backpressure();
        $display("[TB] backpressure run done, %0d failed so far", n_fail);
        test_start_on_done();
        $display("[TB] start-on-done run done, %0d failed so far", n_fail);
        test_reset_mid_run();
        $display("[TB] reset-mid-run done, %0d failed so far", n_fail);
        test_step_timing();
        $display("[TB] step-timing run done, %0d failed so far", n_fail);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
